// File: rtl/sal_cmd_sched_if.sv
// Scheduler bus: per-bank requests and grants, timing inputs, and the registered DFI command port.
// The master side is the bank-controller/PHY pair and the slave side is the scheduler.
interface sal_cmd_sched_if #(
  parameter int NUM_BANKS  = 8,
  parameter int BA_WIDTH   = 3,
  parameter int RA_WIDTH   = 14,
  parameter int CA_WIDTH   = 10,
  parameter int ADDR_WIDTH = 14,
  parameter int CS_WIDTH   = 1,
  parameter int TW         = 4
);
  logic [TW-1:0]                  t_rrd, t_ccd, t_wtr, t_rtw;
  logic [NUM_BANKS-1:0]           act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NUM_BANKS*RA_WIDTH-1:0]  ra;
  logic [NUM_BANKS*CA_WIDTH-1:0]  ca;
  logic [NUM_BANKS-1:0]           act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic                           cke;
  logic [CS_WIDTH-1:0]            cs_n;
  logic                           ras_n, cas_n, we_n;
  logic [BA_WIDTH-1:0]            ba;
  logic [ADDR_WIDTH-1:0]          addr;
  logic                           odt;

  modport master (
    output t_rrd, t_ccd, t_wtr, t_rtw, act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt
  );
  modport slave (
    input  t_rrd, t_ccd, t_wtr, t_rtw, act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt
  );
endinterface

// File: rtl/sal_cmd_sched.sv
// N-bank DDR2 command scheduler: one combinational grant per cycle (or an all-bank REF),
// round-robin within the winning class, inter-bank timers, registered DFI command.
module sal_cmd_sched #(
  parameter int NUM_BANKS  = 8,
  parameter int BA_WIDTH   = 3,
  parameter int RA_WIDTH   = 14,
  parameter int CA_WIDTH   = 10,
  parameter int ADDR_WIDTH = 14,
  parameter int CS_WIDTH   = 1,
  parameter int TW         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sal_cmd_sched_if.slave  sched_if
);
  typedef enum logic [2:0] {C_NONE, C_REF, C_CAS, C_ACT, C_PRE} cls_e;

  logic                  r_cke, r_ras_n, r_cas_n, r_we_n, r_odt;
  logic [CS_WIDTH-1:0]   r_cs_n;
  logic [BA_WIDTH-1:0]   r_ba, r_rr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TW-1:0]         r_rrd, r_ccd, r_wtr, r_rtw;

  logic [NUM_BANKS-1:0]  w_rd_ok, w_wr_ok, w_act_ok, w_cand;
  logic [NUM_BANKS-1:0]  w_act_gnt, w_rd_gnt, w_wr_gnt, w_pre_gnt, w_ref_gnt;
  logic [BA_WIDTH-1:0]   w_bank, w_idx;
  logic                  w_hit, w_is_wr;
  logic [RA_WIDTH-1:0]   w_row;
  logic [CA_WIDTH-1:0]   w_col;
  cls_e                  w_cls;

  // A programmed value t spaces commands by t cycles, so the counter holds t-1 (t=0 acts as t=1).
  function automatic logic [TW-1:0] tload(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [TW-1:0] tdec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  always_comb begin
    w_rd_ok  = (r_ccd == '0 && r_wtr == '0) ? sched_if.rd_req : '0;
    w_wr_ok  = (r_ccd == '0 && r_rtw == '0) ? sched_if.wr_req : '0;
    w_act_ok = (r_rrd == '0) ? sched_if.act_req : '0;
    w_cls    = C_NONE;
    w_cand   = '0;
    if (!r_cke)                    w_cls = C_NONE;
    else if (&sched_if.ref_req)    w_cls = C_REF;
    else if (|(w_rd_ok | w_wr_ok)) begin w_cls = C_CAS; w_cand = w_rd_ok | w_wr_ok; end
    else if (|w_act_ok)            begin w_cls = C_ACT; w_cand = w_act_ok; end
    else if (|sched_if.pre_req)    begin w_cls = C_PRE; w_cand = sched_if.pre_req; end

    // Round-robin scan from r_rr; BA_WIDTH-bit addition wraps modulo NUM_BANKS.
    w_hit  = 1'b0;
    w_bank = '0;
    w_idx  = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_idx = r_rr + BA_WIDTH'(k);
      if (!w_hit && w_cand[w_idx]) begin
        w_hit  = 1'b1;
        w_bank = w_idx;
      end
    end

    w_is_wr   = (w_cls == C_CAS) && !w_rd_ok[w_bank];
    w_row     = sched_if.ra[w_bank*RA_WIDTH +: RA_WIDTH];
    w_col     = sched_if.ca[w_bank*CA_WIDTH +: CA_WIDTH];
    w_act_gnt = '0;
    w_rd_gnt  = '0;
    w_wr_gnt  = '0;
    w_pre_gnt = '0;
    w_ref_gnt = (w_cls == C_REF) ? '1 : '0;
    if (w_hit) begin
      case (w_cls)
        C_CAS:   if (w_is_wr) w_wr_gnt[w_bank] = 1'b1; else w_rd_gnt[w_bank] = 1'b1;
        C_ACT:   w_act_gnt[w_bank] = 1'b1;
        C_PRE:   w_pre_gnt[w_bank] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cke <= 1'b0; r_cs_n <= '1; r_ras_n <= 1'b1; r_cas_n <= 1'b1; r_we_n <= 1'b1;
      r_ba  <= '0;   r_addr <= '0; r_odt   <= 1'b0; r_rr    <= '0;
      r_rrd <= '0;   r_ccd  <= '0; r_wtr   <= '0;   r_rtw   <= '0;
    end else begin
      r_cke <= 1'b1; r_cs_n <= '0; r_ras_n <= 1'b1; r_cas_n <= 1'b1; r_we_n <= 1'b1;
      r_ba  <= '0;   r_addr <= '0; r_odt   <= 1'b0;
      r_rrd <= tdec(r_rrd); r_ccd <= tdec(r_ccd); r_wtr <= tdec(r_wtr); r_rtw <= tdec(r_rtw);
      case (w_cls)
        C_REF: begin r_ras_n <= 1'b0; r_cas_n <= 1'b0; end
        C_ACT: begin
          r_ras_n <= 1'b0; r_ba <= w_bank; r_addr <= ADDR_WIDTH'(w_row);
          r_rrd   <= tload(sched_if.t_rrd); r_rr <= w_bank + 1'b1;
        end
        C_CAS: begin
          r_cas_n <= 1'b0; r_we_n <= !w_is_wr; r_odt <= w_is_wr;
          r_ba    <= w_bank; r_addr <= ADDR_WIDTH'(w_col);
          r_ccd   <= tload(sched_if.t_ccd); r_rr <= w_bank + 1'b1;
          if (w_is_wr) r_wtr <= tload(sched_if.t_wtr);
          else         r_rtw <= tload(sched_if.t_rtw);
        end
        C_PRE: begin
          r_ras_n <= 1'b0; r_we_n <= 1'b0; r_ba <= w_bank; r_rr <= w_bank + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sched_if.act_gnt = w_act_gnt;
  assign sched_if.rd_gnt  = w_rd_gnt;
  assign sched_if.wr_gnt  = w_wr_gnt;
  assign sched_if.pre_gnt = w_pre_gnt;
  assign sched_if.ref_gnt = w_ref_gnt;
  assign sched_if.cke     = r_cke;
  assign sched_if.cs_n    = r_cs_n;
  assign sched_if.ras_n   = r_ras_n;
  assign sched_if.cas_n   = r_cas_n;
  assign sched_if.we_n    = r_we_n;
  assign sched_if.ba      = r_ba;
  assign sched_if.addr    = r_addr;
  assign sched_if.odt     = r_odt;
endmodule

// File: tb/tb_sal_cmd_sched.sv
// Directed bench for sal_cmd_sched: grant checks issue expected DFI commands into a scoreboard
// that a negedge bus monitor drains.
module tb_sal_cmd_sched;
  localparam int NB = 8, BAW = 3, RAW = 14, CAW = 10, AW = 14, CSW = 1, TW = 4;
  localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_REF = 4;

  typedef struct {
    int             cyc;
    logic [2:0]     cmd;
    logic [BAW-1:0] ba;
    logic [AW-1:0]  addr;
    logic           odt;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   s;
  bus_t sbq[$];
  bus_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sal_cmd_sched_if #(.NUM_BANKS(NB), .BA_WIDTH(BAW), .RA_WIDTH(RAW), .CA_WIDTH(CAW),
                     .ADDR_WIDTH(AW), .CS_WIDTH(CSW), .TW(TW)) bus ();
  sal_cmd_sched #(.NUM_BANKS(NB), .BA_WIDTH(BAW), .RA_WIDTH(RAW), .CA_WIDTH(CAW),
                  .ADDR_WIDTH(AW), .CS_WIDTH(CSW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .sched_if(bus));

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [RAW-1:0] ra_of(input int b);
    return RAW'(32'h1000 + b * 3);
  endfunction

  function automatic logic [CAW-1:0] ca_of(input int b);
    return CAW'(32'h040 + b * 5);
  endfunction

  function automatic logic [2:0] cmd_of(input int k);
    case (k)
      K_ACT:   return 3'b011;
      K_RD:    return 3'b101;
      K_WR:    return 3'b100;
      K_PRE:   return 3'b010;
      K_REF:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    bus.act_req = '0; bus.rd_req = '0; bus.wr_req = '0; bus.pre_req = '0; bus.ref_req = '0;
  endtask

  // Waits (bounded) for the next grant, checks it, queues the DFI command due one cycle later.
  task automatic expect_gnt(input int kind, input int bank, input int exp_cyc, input bit drop);
    bit   seen = 0;
    int   k = -1, b = -1;
    bus_t e;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (|{bus.act_gnt, bus.rd_gnt, bus.wr_gnt, bus.pre_gnt, bus.ref_gnt}) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL gnt_timeout: no grant seen, expected kind %0d bank %0d", kind, bank);
      return;
    end
    if (|bus.ref_gnt) begin
      k = K_REF; b = 0;
      cmp("ref_gnt_all", 32'(bus.ref_gnt), 32'({NB{1'b1}}));
      cmp("ref_excl", 32'(|{bus.act_gnt, bus.rd_gnt, bus.wr_gnt, bus.pre_gnt}), 32'd0);
    end else begin
      cmp("gnt_onehot", $countones({bus.act_gnt, bus.rd_gnt, bus.wr_gnt, bus.pre_gnt}), 32'd1);
      for (int i = 0; i < NB; i++) begin
        if (bus.act_gnt[i]) begin k = K_ACT; b = i; end
        if (bus.rd_gnt[i])  begin k = K_RD;  b = i; end
        if (bus.wr_gnt[i])  begin k = K_WR;  b = i; end
        if (bus.pre_gnt[i]) begin k = K_PRE; b = i; end
      end
    end
    cmp("gnt_kind", k, kind);
    cmp("gnt_bank", b, bank);
    cmp("gnt_cycle", cyc, exp_cyc);
    e.cyc  = exp_cyc + 1;
    e.cmd  = cmd_of(kind);
    e.ba   = (kind == K_REF) ? '0 : BAW'(bank);
    e.addr = (kind == K_ACT) ? AW'(ra_of(bank)) :
             (kind == K_RD || kind == K_WR) ? AW'(ca_of(bank)) : '0;
    e.odt  = (kind == K_WR);
    sbq.push_back(e);
    if (drop) begin
      tick();
      case (kind)
        K_ACT:   bus.act_req[bank] = 1'b0;
        K_RD:    bus.rd_req[bank]  = 1'b0;
        K_WR:    bus.wr_req[bank]  = 1'b0;
        K_PRE:   bus.pre_req[bank] = 1'b0;
        default: bus.ref_req       = '0;
      endcase
    end
  endtask

  // Bus monitor: every non-NOP command must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.cke === 1'b1) begin
      if (bus.cs_n == '0 && {bus.ras_n, bus.cas_n, bus.we_n} != 3'b111) begin
        if (sbq.size() == 0) begin
          cmp("unexpected_cmd", 32'({bus.ras_n, bus.cas_n, bus.we_n}), 32'h7);
        end else begin
          mon_e = sbq.pop_front();
          cmp("cmd_cycle", cyc, mon_e.cyc);
          cmp("cmd_code", 32'({bus.ras_n, bus.cas_n, bus.we_n}), 32'(mon_e.cmd));
          cmp("cmd_ba", 32'(bus.ba), 32'(mon_e.ba));
          cmp("cmd_addr", 32'(bus.addr), 32'(mon_e.addr));
          cmp("cmd_odt", 32'(bus.odt), 32'(mon_e.odt));
        end
      end else begin
        cmp("nop_odt", 32'(bus.odt), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_req();
    bus.t_rrd = '0; bus.t_ccd = '0; bus.t_wtr = '0; bus.t_rtw = '0;
    for (int b = 0; b < NB; b++) begin
      bus.ra[b*RAW +: RAW] = ra_of(b);
      bus.ca[b*CAW +: CAW] = ca_of(b);
    end

    // Reset: requests ignored, bus idle with chip deselected
    repeat (2) tick();
    bus.act_req = '1; bus.rd_req = '1; bus.ref_req = '1;
    @(negedge clk);
    cmp("rst_gnts", 32'(|{bus.act_gnt, bus.rd_gnt, bus.wr_gnt, bus.pre_gnt, bus.ref_gnt}), 32'd0);
    cmp("rst_cs_n", 32'(bus.cs_n), 32'({CSW{1'b1}}));
    cmp("rst_cke", 32'(bus.cke), 32'd0);
    cmp("rst_cmd", 32'({bus.ras_n, bus.cas_n, bus.we_n, bus.odt}), 32'hE);
    clr_req();
    rst_n = 1'b1;
    @(negedge clk);
    cmp("rel_cke", 32'(bus.cke), 32'd1);
    cmp("rel_nop", 32'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n}), 32'h7);

    // tRRD = 4
    bus.t_rrd = 4'd4; bus.t_ccd = 4'd1; bus.t_wtr = 4'd1; bus.t_rtw = 4'd1;
    tick();
    bus.act_req = 8'h03; s = cyc;
    expect_gnt(K_ACT, 0, s, 1);
    expect_gnt(K_ACT, 1, s + 4, 1);
    repeat (4) tick();

    // Turnarounds: WR->RD after tWTR, RD->WR after tRTW
    bus.t_rrd = 4'd1; bus.t_wtr = 4'd3; bus.t_rtw = 4'd2; bus.t_ccd = 4'd1;
    bus.wr_req[2] = 1'b1; bus.rd_req[3] = 1'b1; s = cyc;
    expect_gnt(K_WR, 2, s, 1);
    expect_gnt(K_RD, 3, s + 3, 1);
    repeat (4) tick();
    bus.rd_req[4] = 1'b1; bus.wr_req[5] = 1'b1; s = cyc;
    expect_gnt(K_RD, 4, s, 1);
    expect_gnt(K_WR, 5, s + 2, 1);
    repeat (2) tick();

    // Reset mid-operation: a grant in flight never reaches the bus
    bus.act_req[0] = 1'b1;
    @(negedge clk);
    cmp("mid_gnt", 32'(bus.act_gnt), 32'h01);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("mid_rst_cs_n", 32'(bus.cs_n), 32'({CSW{1'b1}}));
    cmp("mid_rst_cmd", 32'({bus.ras_n, bus.cas_n, bus.we_n, bus.odt}), 32'hE);
    cmp("mid_rst_gnt", 32'(bus.act_gnt), 32'd0);
    cmp("mid_rst_cke", 32'(bus.cke), 32'd0);
    clr_req();
    rst_n = 1'b1;
    @(negedge clk);
    cmp("mid_rel_nop", 32'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n}), 32'h7);

    // Round-robin from rr=0 with zero timers (t=0 acts as t=1)
    bus.t_rrd = '0; bus.t_ccd = '0; bus.t_wtr = '0; bus.t_rtw = '0;
    tick();
    bus.rd_req = '1; s = cyc;
    for (int k = 0; k < 9; k++) expect_gnt(K_RD, k % NB, s + k, 0);
    tick();
    clr_req();
    // Grant to bank 4 moves rr to 5
    bus.rd_req[4] = 1'b1; s = cyc;
    expect_gnt(K_RD, 4, s, 1);
    bus.rd_req = '1; s = cyc;
    for (int k = 0; k < 4; k++) expect_gnt(K_RD, (5 + k) % NB, s + k, 0);
    tick();
    clr_req();

    // Class priority: CAS > ACT > PRE
    bus.t_rrd = 4'd1; bus.t_ccd = 4'd1; bus.t_wtr = 4'd1; bus.t_rtw = 4'd1;
    tick();
    bus.pre_req[1] = 1'b1; bus.act_req[2] = 1'b1; bus.wr_req[3] = 1'b1; s = cyc;
    expect_gnt(K_WR, 3, s, 1);
    expect_gnt(K_ACT, 2, s + 1, 1);
    expect_gnt(K_PRE, 1, s + 2, 1);

    // Refresh wins over pending reads and leaves rr (=2) untouched
    tick();
    bus.ref_req = '1; bus.rd_req[0] = 1'b1; bus.rd_req[1] = 1'b1; bus.rd_req[3] = 1'b1; s = cyc;
    expect_gnt(K_REF, 0, s, 1);
    expect_gnt(K_RD, 3, s + 1, 1);
    expect_gnt(K_RD, 0, s + 2, 1);
    expect_gnt(K_RD, 1, s + 3, 1);

    // Partial refresh vector is never granted
    tick();
    bus.ref_req = 8'h7F;
    repeat (3) begin
      @(negedge clk);
      cmp("partial_ref", 32'(|{bus.act_gnt, bus.rd_gnt, bus.wr_gnt, bus.pre_gnt, bus.ref_gnt}), 32'd0);
    end
    tick();
    clr_req();

    repeat (3) @(negedge clk);
    cmp("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sal_cmd_sched.md
# sal_cmd_sched

Parametrised N-bank DDR2 command scheduler between the per-bank controllers and the DFI control port. Each cycle it picks at most one pending ACT/RD/WR/PRE/REF request from the banks and grants it. It enforces the inter-bank timing constraints tRRD, tCCD, tWTR and tRTW, and drives the registered DFI command bus. Bank count, address widths and timer widths are parameters, and the block adds round-robin fairness and an all-bank refresh mode.

## Interface
- NUM_BANKS, 8, banks served (power of 2, ≥2)
- BA_WIDTH, 3, log2(NUM_BANKS)
- RA_WIDTH, 14, row address width
- CA_WIDTH, 10, column address width (≤10; A10 is reserved)
- ADDR_WIDTH, 14, DFI address width (≥RA_WIDTH, ≥11)
- CS_WIDTH, 1, chip selects
- TW, 4, timer width for all timing inputs

Ports:
- clk  in  1  controller clock
- rst_n  in  1  reset; asynchronous, active-low
- t_rrd, t_ccd, t_wtr, t_rtw  in  TW each  timing in cycles; quasi-static
- act_req, rd_req, wr_req, pre_req, ref_req  in  NUM_BANKS each  per-bank requests; a bank raises at most one at a time
- ra  in  NUM_BANKS*RA_WIDTH  row per bank; bank i at [i*RA_WIDTH +: RA_WIDTH]
- ca  in  NUM_BANKS*CA_WIDTH  column per bank, same packing
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  out  NUM_BANKS each  combinational grants
- cke  out  1  DFI clock enable
- cs_n  out  CS_WIDTH  DFI chip select; all bits driven identically
- ras_n, cas_n, we_n  out  1 each  DFI command
- ba  out  BA_WIDTH  DFI bank address
- addr  out  ADDR_WIDTH  DFI address
- odt  out  1  on-die termination

## Operation
- **Refresh.** When all bits of ref_req are set, every ref_gnt bit is asserted and a REF is issued. Refresh has the highest priority, and no other grant is given that cycle. A partial ref_req vector is never granted.
- **Class priority** (otherwise): CAS (RD/WR) > ACT > PRE. Only the highest class with an eligible request is granted.
- **Eligibility.**
  - ACT: requires rrd_cnt==0.
  - RD: requires ccd_cnt==0 and wtr_cnt==0.
  - WR: requires ccd_cnt==0 and rtw_cnt==0.
  - PRE: always eligible.
- **Arbitration within a class.** Round-robin from pointer rr (reset 0): the first eligible bank at index ≥rr wins, wrapping modulo NUM_BANKS. After any single-bank grant, rr ← granted bank +1, wrapping from NUM_BANKS-1 to 0. REF leaves rr unchanged.
- **One-hot grants.** At most one bit is set across all *_gnt vectors, REF excepted. A grant is never given to a bank that is not requesting.
- **Timer counters** (TW bits, reset 0): each decrements by 1 per cycle, saturating at 0.
  - ACT issue loads rrd_cnt ← max(t_rrd-1, 0).
  - RD or WR issue loads ccd_cnt ← max(t_ccd-1, 0).
  - WR issue loads wtr_cnt ← max(t_wtr-1, 0).
  - RD issue loads rtw_cnt ← max(t_rtw-1, 0).
  - A load overrides the decrement in the same cycle.
  - Net effect: a value t means the next eligible command comes ≥t cycles after the previous one. t=0 behaves as t=1.
- **DFI encoding**, with ras_n/cas_n/we_n listed in that order:
  - NOP: cs_n=0, 1/1/1.
  - ACT: 0/1/1, addr = zero-extended ra.
  - RD: 1/0/1, addr = zero-extended ca with A10=0.
  - WR: 1/0/0, addr as RD.
  - PRE: 0/1/0, A10=0.
  - REF: 0/0/1, addr=0, ba=0.
  - For single-bank commands, ba = granted bank.
- odt is 1 only in the cycle in which a WR is on the bus.
- cke is 0 in reset and is registered to 1 on the first clock edge after rst_n deasserts. No grants are given while cke is 0.

## Timing
- Grants are combinational in the request cycle. The corresponding DFI command is registered and appears in cycle +1 for exactly one cycle, followed by NOP unless another grant occurs.
- Back-to-back grants are legal every cycle, subject to the timer counters.
- Reset values:
  - cke=0, cs_n=all 1, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=0.
  - All grants are 0 while rst_n is low.
  - Counters and rr are 0.
- Reset asserted mid-operation clears everything on the same edge. No partial command may remain on the bus.
- Simultaneous RD and WR requests from different banks are resolved by rr only; neither type has priority over the other.

## Test plan
- **Reset.** Hold rst_n=0, pulse requests → all grants 0, cs_n=1, cke=0. One cycle after release, cke=1, and the bus shows NOP (cs_n=0, 1/1/1).
- **tRRD.** t_rrd=4; banks 0 and 1 hold act_req → act_gnt[0] in cycle n, act_gnt[1] in cycle n+4. On the bus, ACT ba=0 appears at n+1 and ACT ba=1 at n+5, with addr=ra of the respective bank.
- **Turnarounds.** t_wtr=3, t_rtw=2, t_ccd=1:
  - WR bank 2 at cycle n, RD pending on bank 3 → rd_gnt[3] at n+3.
  - Conversely, RD at cycle m → the next WR is granted at m+2.
  - odt=1 only alongside the WR command.
- **Round-robin.** All 8 banks hold rd_req with all timers 0 → rd_gnt one-hot sequence 0,1,…,7,0.
  - Start with rr=5 (after a grant to bank 4) → the sequence starts at 5.
- **Class priority.** Bank 1 pre_req, bank 2 act_req, bank 3 wr_req, all in the same cycle → wr_gnt[3] first. Then act_gnt[2] (rrd_cnt=0). Then pre_gnt[1].
- **Refresh.** ref_req=8'hFF together with rd_req[0] → ref_gnt=8'hFF, rd_gnt=0, bus shows 0/0/1 with addr=0.
  - ref_req=8'h7F → no ref_gnt.
